// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, instruction field positions
// and the opcode slice helper used by the decoder and writeback paths.
package instr_fetch_pkg;

    localparam int INST_W = 16;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2,
        FS_HOLD = 2'd3
    } fetch_state_t;

    localparam int OP_HI_MSB  = 15;
    localparam int OP_HI_LSB  = 12;
    localparam int RDEST_MSB  = 11;
    localparam int RDEST_LSB  = 8;
    localparam int OP_EXT_MSB = 7;
    localparam int OP_EXT_LSB = 4;
    localparam int RSRC_MSB   = 3;
    localparam int RSRC_LSB   = 0;

    // The decoder sees the major opcode nibble joined with the extension nibble.
    function automatic logic [7:0] make_opcode(input logic [INST_W-1:0] ir);
        return {ir[OP_HI_MSB:OP_HI_LSB], ir[OP_EXT_MSB:OP_EXT_LSB]};
    endfunction

endpackage

// File: rtl/instr_fields.sv
// Instruction field slicer: IR -> opcode/rdest/rsrc/imm8.
// Purely combinational, zero latency; no flow control.
module instr_fields
    import instr_fetch_pkg::*;
(
    input  logic [INST_W-1:0] ir,
    output logic [7:0]        opcode,
    output logic [3:0]        rdest,
    output logic [3:0]        rsrc,
    output logic [7:0]        imm8
);

    assign opcode = make_opcode(ir);
    assign rdest  = ir[RDEST_MSB:RDEST_LSB];
    assign rsrc   = ir[RSRC_MSB:RSRC_LSB];
    assign imm8   = ir[OP_EXT_MSB:RSRC_LSB];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, 1-cycle-latency BRAM read, IR holding register (INSTR_FETCH_CNT_EN adds fetch_count).
// Latency: REQ -> WAIT -> HOLD, first ir_valid 3 cycles after leaving IDLE; one instruction per 3 cycles.
// Backpressure: ir_ready=0 parks the IR in HOLD and blocks the next memory request.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    output logic               mem_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INST_W-1:0]  mem_rdata,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [7:0]         opcode,
    output logic [3:0]         rdest,
    output logic [3:0]         rsrc,
    output logic [7:0]         imm8,
    output logic [ADDR_W-1:0]  ir_pc,
    input  logic               redirect_en,
    input  logic [ADDR_W-1:0]  redirect_pc
`ifdef INSTR_FETCH_CNT_EN
    ,
    output logic [15:0]        fetch_count
`endif
);

    fetch_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0]   ir_q, ir_d;
    logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        case (state_q)
            FS_IDLE: if (fetch_en) state_d = FS_REQ;
            FS_REQ:  state_d = FS_WAIT;
            FS_WAIT: begin
                ir_d    = mem_rdata;
                ir_pc_d = pc_q;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = FS_HOLD;
            end
            FS_HOLD: if (ir_ready) state_d = fetch_en ? FS_REQ : FS_IDLE;
            default: state_d = FS_IDLE;
        endcase
        // Redirect overrides everything: any in-flight read is dropped and the IR is left as is.
        if (redirect_en) begin
            pc_d    = redirect_pc;
            ir_d    = ir_q;
            ir_pc_d = ir_pc_q;
            state_d = (state_q == FS_IDLE && !fetch_en) ? FS_IDLE : FS_REQ;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ir_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
        end
    end

    assign mem_en   = (state_q == FS_REQ);
    assign mem_addr = pc_q;
    assign ir_valid = (state_q == FS_HOLD);
    assign ir_pc    = ir_pc_q;

    instr_fields u_fields (
        .ir     (ir_q),
        .opcode (opcode),
        .rdest  (rdest),
        .rsrc   (rsrc),
        .imm8   (imm8)
    );

`ifdef INSTR_FETCH_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // A handshake coinciding with a redirect still counts: that instruction was consumed.
    always_comb begin
        cnt_d = cnt_q;
        if (ir_valid && ir_ready) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign fetch_count = cnt_q;
`endif

endmodule
